// File: rtl/rob_multi_commit_pkg.sv
// rob_multi_commit_pkg: shared defaults and entry/commit record types for the reorder buffer
package rob_multi_commit_pkg;
   localparam int ROB_ENTRIES_DEF  = 16;
   localparam int COMMIT_WIDTH_DEF = 2;
   localparam int ROB_IDX_W        = $clog2(ROB_ENTRIES_DEF);
   typedef struct packed {
      logic        valid;
      logic        done;
      logic        mispred;
      logic [4:0]  dst_areg;
      logic [5:0]  dst_preg;
      logic [5:0]  old_preg;
      logic [31:0] pc;
      logic [31:0] tgt_pc;
   } rob_entry_t;
   typedef struct packed {
      logic [4:0] dst_areg;
      logic [5:0] dst_preg;
      logic [5:0] old_preg;
   } rob_commit_t;
endpackage

// File: rtl/rob_commit_select.sv
// rob_commit_select: in-order prefix scan over the retirement window starting at head
//   ent_valid/ent_done/ent_mispred : state of entries head+0 .. head+CW-1
//   commit_valid                   : thermometer mask of slots retiring this cycle
//   flush_sel                      : one-hot slot of the retiring mispredict (zero if none)
module rob_commit_select #(
   parameter int CW = 2
) (
   input  logic [CW-1:0] ent_valid,
   input  logic [CW-1:0] ent_done,
   input  logic [CW-1:0] ent_mispred,
   output logic [CW-1:0] commit_valid,
   output logic [CW-1:0] flush_sel
);
   logic ok;
   always_comb begin
      ok           = 1'b1;
      commit_valid = '0;
      flush_sel    = '0;
      for (int k = 0; k < CW; k++) begin
         commit_valid[k] = ok & ent_valid[k] & ent_done[k];
         flush_sel[k]    = commit_valid[k] & ent_mispred[k];
         // a mispredict retires but closes the window for younger slots
         ok              = commit_valid[k] & ~ent_mispred[k];
      end
   end
endmodule

// File: rtl/rob_multi_commit.sv
// rob_multi_commit: reorder buffer with multi-port completion, multi-wide in-order commit and mispredict flush
//   disp_*   : dispatch handshake and entry payload; disp_rob_idx is the tail slot
//   cmpl_*   : per-FU completion strobes, flattened per port
//   commit_* : per-slot retirement, slot 0 oldest
//   flush_*  : redirect raised in the cycle a mispredicted entry retires
//   rob_count/rob_empty : occupancy
module rob_multi_commit
   import rob_multi_commit_pkg::*;
#(
   parameter int ROB_ENTRIES  = ROB_ENTRIES_DEF,
   parameter int NUM_FUS      = 4,
   parameter int COMMIT_WIDTH = COMMIT_WIDTH_DEF,
   parameter int IDX_W        = $clog2(ROB_ENTRIES)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      disp_valid,
   output logic                      disp_ready,
   input  logic [4:0]                disp_dst_areg,
   input  logic [5:0]                disp_dst_preg,
   input  logic [5:0]                disp_old_preg,
   input  logic [31:0]               disp_pc,
   output logic [IDX_W-1:0]          disp_rob_idx,
   input  logic [NUM_FUS-1:0]        cmpl_valid,
   input  logic [NUM_FUS*IDX_W-1:0]  cmpl_rob_idx,
   input  logic [NUM_FUS-1:0]        cmpl_mispred,
   input  logic [NUM_FUS*32-1:0]     cmpl_tgt_pc,
   output logic [COMMIT_WIDTH-1:0]   commit_valid,
   output logic [COMMIT_WIDTH*5-1:0] commit_dst_areg,
   output logic [COMMIT_WIDTH*6-1:0] commit_dst_preg,
   output logic [COMMIT_WIDTH*6-1:0] commit_old_preg,
   output logic                      flush_valid,
   output logic [31:0]               flush_pc,
   output logic [IDX_W:0]            rob_count,
   output logic                      rob_empty
);
   rob_entry_t              rob [ROB_ENTRIES];
   rob_commit_t             cm [COMMIT_WIDTH];
   logic [IDX_W-1:0]        head, tail, head_nxt;
   logic [IDX_W:0]          count, pop;
   logic [IDX_W-1:0]        win_idx [COMMIT_WIDTH];
   logic [COMMIT_WIDTH-1:0] win_valid, win_done, win_mispred, flush_sel;
   logic                    fire, full, unused_pc;

   for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : g_win
      assign win_idx[k]     = head + IDX_W'(k);
      assign win_valid[k]   = rob[win_idx[k]].valid;
      assign win_done[k]    = rob[win_idx[k]].done;
      assign win_mispred[k] = rob[win_idx[k]].mispred;
   end

   rob_commit_select #(.CW(COMMIT_WIDTH)) u_sel (
      .ent_valid    (win_valid),
      .ent_done     (win_done),
      .ent_mispred  (win_mispred),
      .commit_valid (commit_valid),
      .flush_sel    (flush_sel)
   );

   always_comb begin
      pop             = '0;
      flush_pc        = '0;
      commit_dst_areg = '0;
      commit_dst_preg = '0;
      commit_old_preg = '0;
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         cm[k] = '0;
         if (commit_valid[k])
            cm[k] = rob_commit_t'{dst_areg: rob[win_idx[k]].dst_areg,
                                  dst_preg: rob[win_idx[k]].dst_preg,
                                  old_preg: rob[win_idx[k]].old_preg};
         commit_dst_areg[k*5 +: 5] = cm[k].dst_areg;
         commit_dst_preg[k*6 +: 6] = cm[k].dst_preg;
         commit_old_preg[k*6 +: 6] = cm[k].old_preg;
         pop      = pop + (IDX_W+1)'(commit_valid[k]);
         flush_pc = flush_pc | (flush_sel[k] ? rob[win_idx[k]].tgt_pc : 32'h0);
      end
   end

   // pc is carried per entry for trace visibility only; nothing downstream consumes it
   always_comb begin
      unused_pc = 1'b0;
      for (int i = 0; i < ROB_ENTRIES; i++) unused_pc = unused_pc ^ (^rob[i].pc);
   end

   assign flush_valid  = |flush_sel;
   assign full         = count == (IDX_W+1)'(ROB_ENTRIES);
   assign disp_ready   = !full && !flush_valid;
   assign fire         = disp_valid && disp_ready;
   assign head_nxt     = head + pop[IDX_W-1:0];
   assign disp_rob_idx = tail;
   assign rob_count    = count;
   assign rob_empty    = count == '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < ROB_ENTRIES; i++) rob[i] <= '0;
      end else begin
         head <= head_nxt;
         if (flush_valid) begin
            tail  <= head_nxt;
            count <= '0;
            for (int i = 0; i < ROB_ENTRIES; i++) rob[i].valid <= 1'b0;
         end else begin
            tail  <= tail + IDX_W'(fire);
            count <= count + (IDX_W+1)'(fire) - pop;
            for (int p = 0; p < NUM_FUS; p++)
               if (cmpl_valid[p] && rob[cmpl_rob_idx[p*IDX_W +: IDX_W]].valid) begin
                  rob[cmpl_rob_idx[p*IDX_W +: IDX_W]].done    <= 1'b1;
                  rob[cmpl_rob_idx[p*IDX_W +: IDX_W]].mispred <= cmpl_mispred[p];
                  rob[cmpl_rob_idx[p*IDX_W +: IDX_W]].tgt_pc  <= cmpl_tgt_pc[p*32 +: 32];
               end
            for (int k = 0; k < COMMIT_WIDTH; k++)
               if (commit_valid[k]) rob[win_idx[k]].valid <= 1'b0;
            // tail never aliases a retiring slot: full blocks dispatch and empty retires nothing
            if (fire)
               rob[tail] <= '{valid: 1'b1, done: 1'b0, mispred: 1'b0,
                              dst_areg: disp_dst_areg, dst_preg: disp_dst_preg,
                              old_preg: disp_old_preg, pc: disp_pc, tgt_pc: 32'h0};
         end
      end
   end

   // two ports completing the same entry in one cycle is an upstream protocol error
   always_ff @(posedge clk) begin
      for (int p = 0; p < NUM_FUS; p++)
         for (int q = p + 1; q < NUM_FUS; q++)
            assert (!rst_n || !(cmpl_valid[p] && cmpl_valid[q] &&
                    cmpl_rob_idx[p*IDX_W +: IDX_W] == cmpl_rob_idx[q*IDX_W +: IDX_W]));
   end
endmodule
